// File: rtl/sauria_pkg.sv
// Shared SAURIA definitions: SRAM C geometry defaults and the
// partial-sum packer FSM state encoding.
package sauria_pkg;

    localparam int DEF_OC_W    = 16;
    localparam int DEF_SRAMC_W = 128;
    localparam int DEF_SRAMC_N = DEF_SRAMC_W / DEF_OC_W;
    localparam int DEF_ADRC_W  = 11;

    typedef enum logic [1:0] {
        PP_IDLE  = 2'd0,
        PP_FILL  = 2'd1,
        PP_WRITE = 2'd2,
        PP_DONE  = 2'd3
    } pp_state_e;

endpackage

// File: rtl/sauria_psum_packer.sv
// Packs OC_W-bit partial sums LSB-first into SRAMC_W-bit SRAM C words
// and writes i_n_words consecutive words starting at i_base_addr.
// Ports: i_clk/i_rst (async high), i_start/i_base_addr/i_n_words (job),
//   i_psum_data/i_psum_valid/o_psum_ready (element stream), i_flush
//   (close partial word), o_sramc_* (write port), o_busy/o_done (status).
// Build option: PSUM_PACKER_WMASK_EN drives a per-slot fill mask on
//   o_sramc_wmask; otherwise the mask is tied all-ones.
module sauria_psum_packer
    import sauria_pkg::*;
#(
    parameter int OC_W    = DEF_OC_W,
    parameter int SRAMC_W = DEF_SRAMC_W,
    parameter int SRAMC_N = SRAMC_W / OC_W,
    parameter int ADRC_W  = DEF_ADRC_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ADRC_W-1:0]  i_base_addr,
    input  logic [ADRC_W:0]    i_n_words,
    input  logic [OC_W-1:0]    i_psum_data,
    input  logic               i_psum_valid,
    output logic               o_psum_ready,
    input  logic               i_flush,
    output logic               o_sramc_wren,
    output logic [ADRC_W-1:0]  o_sramc_addr,
    output logic [SRAMC_W-1:0] o_sramc_wdata,
    output logic [SRAMC_N-1:0] o_sramc_wmask,
    output logic               o_busy,
    output logic               o_done
);

    localparam int SLOT_W = (SRAMC_N > 1) ? $clog2(SRAMC_N) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SRAMC_N - 1);

    pp_state_e          state;
    logic [SLOT_W-1:0]  slot;
    logic [ADRC_W-1:0]  addr;
    logic [ADRC_W:0]    remain;
    logic [SRAMC_W-1:0] data;
    logic               xfer;
    logic               close;

    assign o_psum_ready = (state == PP_FILL);
    assign xfer         = i_psum_valid && o_psum_ready;

    // A word closes when its last slot fills, or on a flush once it
    // holds at least one element (counting one arriving this cycle).
    assign close = (xfer && (slot == LAST_SLOT))
                || (o_psum_ready && i_flush && (xfer || (slot != '0)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= PP_IDLE;
            slot   <= '0;
            addr   <= '0;
            remain <= '0;
            data   <= '0;
        end else begin
            unique case (state)
                PP_IDLE: begin
                    if (i_start) begin
                        addr   <= i_base_addr;
                        remain <= i_n_words;
                        slot   <= '0;
                        data   <= '0;
                        state  <= (i_n_words == '0) ? PP_DONE : PP_FILL;
                    end
                end
                PP_FILL: begin
                    if (xfer) begin
                        data[int'(slot)*OC_W +: OC_W] <= i_psum_data;
                        slot <= slot + 1'b1;
                    end
                    if (close) begin
                        state <= PP_WRITE;
                    end
                end
                PP_WRITE: begin
                    // Clearing here keeps unfilled slots of the next
                    // word zero without a separate pad step.
                    addr   <= addr + 1'b1;
                    remain <= remain - 1'b1;
                    slot   <= '0;
                    data   <= '0;
                    if (remain == (ADRC_W+1)'(1)) begin
                        state <= PP_DONE;
                    end else begin
                        state <= PP_FILL;
                    end
                end
                PP_DONE: begin
                    state <= PP_IDLE;
                end
            endcase
        end
    end

`ifdef PSUM_PACKER_WMASK_EN
    logic [SRAMC_N-1:0] fill_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_mask <= '0;
        end else if (state == PP_WRITE) begin
            fill_mask <= '0;
        end else if (state == PP_IDLE && i_start) begin
            fill_mask <= '0;
        end else if (xfer) begin
            fill_mask[slot] <= 1'b1;
        end
    end

    assign o_sramc_wmask = (state == PP_WRITE) ? fill_mask : '0;
`else
    assign o_sramc_wmask = '1;
`endif

    assign o_sramc_wren  = (state == PP_WRITE);
    assign o_sramc_addr  = addr;
    assign o_sramc_wdata = data;
    assign o_busy        = (state != PP_IDLE);
    assign o_done        = (state == PP_DONE);

endmodule

// File: tb/tb_sauria_psum_packer.sv
// Directed bench for sauria_psum_packer: table of transfer jobs plus
// hand-written start/flush-ignore and mid-transfer reset sequences.
module tb_sauria_psum_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [10:0]  base = '0;
    logic [11:0]  nw = '0;
    logic [15:0]  pdata = '0;
    logic         pvalid = 1'b0;
    logic         pready;
    logic         flush = 1'b0;
    logic         wren;
    logic [10:0]  waddr;
    logic [127:0] wdata;
    logic [7:0]   wmask;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0]  base;
        logic [11:0]  nw;
        int           ne;
        bit           wl;
        logic [15:0]  seed;
        int           exp_wr;
        logic [10:0]  exp_addr_last;
        logic [127:0] exp_wdata0;
        logic [7:0]   exp_mask0;
    } vec_t;

    vec_t vecs[6];

    sauria_psum_packer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_base_addr   (base),
        .i_n_words     (nw),
        .i_psum_data   (pdata),
        .i_psum_valid  (pvalid),
        .o_psum_ready  (pready),
        .i_flush       (flush),
        .o_sramc_wren  (wren),
        .o_sramc_addr  (waddr),
        .o_sramc_wdata (wdata),
        .o_sramc_wmask (wmask),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mask_exp(input logic [7:0] on_val);
`ifdef PSUM_PACKER_WMASK_EN
        return on_val;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wren"}, 128'(wren), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_ready"}, 128'(pready), 128'(0));
        chk({tag, "_addr"}, 128'(waddr), 128'(0));
        chk({tag, "_wdata"}, wdata, 128'(0));
        chk({tag, "_mask"}, 128'(wmask), 128'(mask_exp(8'h00)));
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [10:0]  wa[$];
        logic [127:0] wd[$];
        logic [7:0]   wm[$];
        int need, sent, tot, cyc, wr_cyc, done_cyc, done_cnt;
        bit seen;
        logic [127:0] md;
        logic [7:0]   mm;
        need = int'(v.nw) * v.ne;
        sent = 0; tot = 0; cyc = 0;
        wr_cyc = -1; done_cyc = -1; done_cnt = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; base = v.base; nw = v.nw;
        @(negedge clk);
        start = 1'b0;
        while (!seen && cyc < 300) begin
            if (wren) begin
                wa.push_back(waddr); wd.push_back(wdata);
                wm.push_back(wmask);
                wr_cyc = cyc; sent = 0;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; seen = 1;
            end
            pvalid = 1'b0; flush = 1'b0; pdata = '0;
            if (sent < v.ne && tot < need) begin
                pvalid = 1'b1;
                pdata  = v.seed + 16'(tot);
                flush  = v.wl && v.ne < 8 && sent == v.ne - 1;
                if (pready) begin
                    sent++; tot++;
                end
            end else if (sent == v.ne && v.ne < 8 && pready) begin
                flush = 1'b1;
            end else if (tot < need) begin
                // keep valid high across WRITE with the next element
                pvalid = 1'b1;
                pdata  = v.seed + 16'(tot);
            end
            @(negedge clk);
            cyc++;
        end
        pvalid = 1'b0; flush = 1'b0;
        chk($sformatf("v%0d_finished", id), 128'(seen), 128'(1));
        for (int i = 0; i < 2; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_done_width", id), 128'(done_cnt), 128'(1));
        chk($sformatf("v%0d_busy_after", id), 128'(busy), 128'(0));
        chk($sformatf("v%0d_nwrites", id), 128'(wa.size()),
            128'(v.exp_wr));
        for (int w = 0; w < wa.size() && w < v.exp_wr; w++) begin
            md = '0;
            for (int k = 0; k < v.ne; k++)
                md[k*16 +: 16] = v.seed + 16'(w * v.ne + k);
            mm = (v.ne == 8) ? 8'hFF : 8'((1 << v.ne) - 1);
            chk($sformatf("v%0d_w%0d_addr", id, w), 128'(wa[w]),
                128'(11'(v.base + 11'(w))));
            chk($sformatf("v%0d_w%0d_data", id, w), wd[w], md);
            chk($sformatf("v%0d_w%0d_mask", id, w), 128'(wm[w]),
                128'(mask_exp(mm)));
        end
        if (v.exp_wr > 0 && wa.size() > 0) begin
            chk($sformatf("v%0d_wdata0", id), wd[0], v.exp_wdata0);
            chk($sformatf("v%0d_mask0", id), 128'(wm[0]),
                128'(mask_exp(v.exp_mask0)));
            chk($sformatf("v%0d_addr_last", id), 128'(wa[wa.size()-1]),
                128'(v.exp_addr_last));
            chk($sformatf("v%0d_done_lat", id), 128'(done_cyc - wr_cyc),
                128'(1));
        end
    endtask

    initial begin
        int wr_seen;
        vecs[0] = '{11'h010, 12'd1, 8, 1'b0, 16'h0001, 1, 11'h010,
                    128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF};
        vecs[1] = '{11'h020, 12'd1, 3, 1'b0, 16'h000A, 1, 11'h020,
                    128'h000C_000B_000A, 8'h07};
        vecs[2] = '{11'h7FF, 12'd2, 8, 1'b0, 16'h0100, 2, 11'h000,
                    128'h0107_0106_0105_0104_0103_0102_0101_0100, 8'hFF};
        vecs[3] = '{11'h005, 12'd0, 8, 1'b0, 16'h0000, 0, 11'h000,
                    128'h0, 8'h00};
        vecs[4] = '{11'h030, 12'd3, 5, 1'b1, 16'h0020, 3, 11'h032,
                    128'h0024_0023_0022_0021_0020, 8'h1F};
        vecs[5] = '{11'h040, 12'd2, 1, 1'b1, 16'hBEEF, 2, 11'h041,
                    128'hBEEF, 8'h01};

        #2;
        chk_idle_outs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // start and slot-0 flush are both ignored while filling
        start = 1'b1; base = 11'h050; nw = 12'd1;
        @(negedge clk);
        base = 11'h060; nw = 12'd0; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("ign_busy", 128'(busy), 128'(1));
        chk("ign_ready", 128'(pready), 128'(1));
        chk("ign_wren", 128'(wren), 128'(0));
        chk("ign_done", 128'(done), 128'(0));
        for (int k = 0; k < 8; k++) begin
            pvalid = 1'b1; pdata = 16'h0900 + 16'(k);
            @(negedge clk);
        end
        pvalid = 1'b0;
        chk("ign_wr_en", 128'(wren), 128'(1));
        chk("ign_wr_addr", 128'(waddr), 128'(11'h050));
        chk("ign_wr_data", wdata,
            128'h0907_0906_0905_0904_0903_0902_0901_0900);
        @(negedge clk);
        chk("ign_done_pulse", 128'(done), 128'(1));
        @(negedge clk);
        chk("ign_idle", 128'(busy), 128'(0));

        // reset after 5 of 8 elements drops the partial word
        start = 1'b1; base = 11'h070; nw = 12'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pvalid = 1'b1; pdata = 16'h0A00 + 16'(k);
            @(negedge clk);
        end
        pvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle_outs("midrst");
        @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wren) wr_seen++;
        end
        chk("midrst_no_write", 128'(wr_seen), 128'(0));
        run_vec(10, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sauria_psum_packer.md
SAURIA_PSUM_PACKER -- requirements
Module: sauria_psum_packer

Interface
REQ-001 SHALL have parameter OC_W, default 16, partial-sum element width.
REQ-002 SHALL have parameter SRAMC_W, default 128, SRAM C word width.
REQ-003 SHALL have parameter SRAMC_N, default SRAMC_W/OC_W (8), elements per word.
REQ-004 SHALL have parameter ADRC_W, default 11, SRAM C address width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_start, input, 1, one-cycle pulse that starts a transfer.
REQ-008 SHALL have port i_base_addr, input, ADRC_W, first SRAM C word address.
REQ-009 SHALL have port i_n_words, input, ADRC_W+1, number of words to write.
REQ-010 SHALL have ports i_psum_data (input, OC_W), i_psum_valid (input, 1) and o_psum_ready (output, 1), the element stream from the array drain.
REQ-011 SHALL have port i_flush, input, 1, closes a partially filled word.
REQ-012 SHALL have ports o_sramc_wren (1), o_sramc_addr (ADRC_W), o_sramc_wdata (SRAMC_W) and o_sramc_wmask (SRAMC_N), all outputs, forming the SRAM C write port.
REQ-013 SHALL have ports o_busy (output, 1) and o_done (output, 1), status.

Function
REQ-014 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-015 IDLE + i_start: SHALL latch i_base_addr and i_n_words; go to FILL, or to DONE if i_n_words==0.
REQ-016 SHALL ignore i_start outside IDLE.
REQ-017 SHALL drive o_psum_ready=1 only in FILL; an element transfers when valid&&ready.
REQ-018 SHALL place element k of a word at bits [k*OC_W +: OC_W], k = slot index 0..SRAMC_N-1, LSB-first.
REQ-019 Transfer at slot SRAMC_N-1: SHALL go to WRITE on the next cycle.
REQ-020 FILL, i_flush=1, slot index>0: SHALL go to WRITE; unfilled slots SHALL be zero.
REQ-021 i_flush with slot index 0 and no transfer SHALL be ignored.
REQ-022 Transfer and i_flush in the same cycle: the element SHALL be included in the word before closing it.
REQ-023 WRITE SHALL last exactly one cycle with o_sramc_wren=1, then increment the address and decrement the remaining count.
REQ-024 After WRITE: remaining count 0 SHALL go to DONE; otherwise SHALL return to FILL with slot index 0.
REQ-025 Address increment SHALL wrap modulo 2**ADRC_W.
REQ-026 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-027 o_busy SHALL be 1 in every state except IDLE.
REQ-028 Latency from the last element accepted to o_sramc_wren SHALL be 1 cycle.
REQ-029 Throughput SHALL be SRAMC_N+1 cycles per full word.

Reset
REQ-030 i_rst SHALL asynchronously force IDLE and clear the slot index, address, count and data register.
REQ-031 During reset all outputs SHALL be 0, except o_sramc_wmask, which follows REQ-033/034.
REQ-032 Reset mid-transfer SHALL discard the partial word with no write issued.

Configuration
REQ-033 With PSUM_PACKER_WMASK_EN defined, o_sramc_wmask bit k SHALL be 1 iff slot k was filled; it SHALL be 0 outside WRITE.
REQ-034 Without PSUM_PACKER_WMASK_EN, o_sramc_wmask SHALL be tied all-ones; flushed words still zero-pad.

Structure
REQ-035 OC_W, SRAMC_W, SRAMC_N and ADRC_W defaults SHALL come from sauria_pkg; the FSM state enum SHALL be added to sauria_pkg.
REQ-036 SHALL be a single module with no sub-modules.

Verification
REQ-037 Full word: base 0x10, n_words 1, elements 1..8 -> one write, addr 0x10, wdata 0x0008_0007_..._0001, mask 0xFF, o_done one cycle later.
REQ-038 Flush: n_words 1, 3 elements 0xA,0xB,0xC then i_flush -> wdata upper 80 bits zero, mask 0x07 (macro on) / 0xFF (macro off).
REQ-039 Wrap: base 0x7FF, n_words 2, 16 elements -> writes at 0x7FF then 0x000.
REQ-040 Backpressure/edge: i_psum_valid held high through WRITE -> no element lost or duplicated; i_n_words 0 -> o_done, no write.
REQ-041 Reset after 5 of 8 elements -> no wren; new i_start accepted normally.
